// File: rtl/trigger_pkg.sv
// Shared types for the D-trigger register bank and its downstream consumers.
package trigger_pkg;

   localparam int unsigned BUS_WIDTH = 10;

   typedef logic [BUS_WIDTH-1:0] bus_t;

endpackage : trigger_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding storage, pointers and fill count.
//   clk, rst   : clock, asynchronous active-low reset
//   push, din  : write request and data; ignored when full unless popping too
//   pop, dout  : read request and head data (dout combinational from storage)
//   full/empty : fill status derived from count
//   count      : entries queued, 0..DEPTH
module sync_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == CW'(0));
   assign dout  = mem[rd_ptr];

   // Storage carries no reset; stale contents are hidden behind empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count follows net change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
         end else if (!push_ok && pop_ok) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule : sync_fifo

// File: rtl/bus_change_detector.sv
// Watches the registered trigger bus and queues every new value for a
// valid/ready consumer.
//   clk, rst  : clock, asynchronous active-low reset
//   inBus     : registered bus from the trigger bank
//   outBus    : FIFO head (combinational), meaningful while outValid=1
//   outValid  : FIFO non-empty
//   outReady  : consumer takes the head on this edge
//   count     : queued entries, 0..DEPTH
//   overflow  : sticky, set when a change was dropped on a full FIFO
module bus_change_detector
   import trigger_pkg::*;
#(
   parameter int unsigned WIDTH = BUS_WIDTH,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         inBus,
   output logic [WIDTH-1:0]         outBus,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   logic [WIDTH-1:0] prev;
   logic             change_c;
   logic             push_c;
   logic             pop_c;
   logic             full;
   logic             empty;

   assign change_c = (inBus != prev);
   assign pop_c    = outValid && outReady;
   assign push_c   = change_c && (!full || pop_c);
   assign outValid = !empty;

   // Previous-value register, refreshed every edge regardless of FIFO state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev <= '0;
      end else begin
         prev <= inBus;
      end
   end

   // Sticky drop flag: a change arrived with no free slot and no pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (change_c && full && !pop_c) begin
         overflow <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .din   (inBus),
      .dout  (outBus),
      .full  (full),
      .empty (empty),
      .count (count)
   );

endmodule : bus_change_detector
